seg_scan_display: RTL and testbench



---
 rtl/seg_scan_display.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_display.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit 7-segment driver: sequential double-dabble binary-to-BCD conversion
// feeding a prescaled digit scanner with leading-zero blanking and overflow dashes.
module seg_scan_display #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          BLANK_LZ       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  count,
  output logic [DIGITS-1:0] seg,
  output logic [6:0]        codeout,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned INT_DIGITS = (WIDTH * 3) / 10 + 1;
  localparam int unsigned EXT_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
  localparam int unsigned BCD_W      = INT_DIGITS * 4;
  localparam int unsigned CNT_W      = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W      = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  state_e              r_state;
  logic [WIDTH-1:0]    r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_ovf;
  logic [DIGITS*4-1:0] r_disp;

  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic                r_active;
  logic [DIGITS-1:0]   r_seg;
  logic [6:0]          r_code;

  logic [BCD_W-1:0]        w_bcd_adj;
  logic [EXT_DIGITS*4-1:0] w_bcd_ext;
  logic                    w_ovf;
  logic                    w_tc;
  logic                    w_active_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic [DIGITS-1:0]       w_seg_next;
  logic [3:0]              w_nib;
  logic                    w_lz_blank;
  logic [6:0]              w_code_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < INT_DIGITS; i++) begin
      if (r_bcd[i*4+:4] >= 4'd5) begin
        w_bcd_adj[i*4+:4] = r_bcd[i*4+:4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_bcd_ext = '0;
    w_bcd_ext[BCD_W-1:0] = r_bcd;
    w_ovf = 1'b0;
    for (int unsigned i = 0; i < EXT_DIGITS; i++) begin
      if (i >= DIGITS && w_bcd_ext[i*4+:4] != 4'd0) begin
        w_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_disp  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_bin   <= count;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= StShift;
        end
        StShift: begin
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= StCommit;
          end
        end
        StCommit: begin
          r_disp  <= w_bcd_ext[DIGITS*4-1:0];
          r_ovf   <= w_ovf;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Scanning stays dark until the first terminal count, which then selects digit 0.
  assign w_tc          = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_active_next = r_active | w_tc;

  always_comb begin
    w_idx_next = r_idx;
    if (w_tc && r_active) begin
      w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_seg_next = '0;
    w_nib      = 4'd0;
    w_lz_blank = (w_idx_next != '0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == w_idx_next) begin
        w_seg_next[i] = w_active_next;
        w_nib         = r_disp[i*4+:4];
      end
      if (IDX_W'(i) >= w_idx_next && r_disp[i*4+:4] != 4'd0) begin
        w_lz_blank = 1'b0;
      end
    end
  end

  always_comb begin
    w_code_next = 7'h00;
    if (w_active_next) begin
      if (r_ovf) begin
        w_code_next = 7'h40;
      end else if (BLANK_LZ && w_lz_blank) begin
        w_code_next = 7'h00;
      end else begin
        w_code_next = seg_decode(w_nib);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_active <= 1'b0;
      r_seg    <= '0;
      r_code   <= 7'h00;
    end else begin
      r_pre    <= w_tc ? '0 : r_pre + 1'b1;
      r_idx    <= w_idx_next;
      r_active <= w_active_next;
      r_seg    <= w_seg_next;
      r_code   <= w_code_next;
    end
  end

  assign seg     = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign codeout = SEG_ACTIVE_LOW ? ~r_code : r_code;
  assign busy    = r_busy;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: three instances (3-digit, 5-digit, 3-digit active-low)
// share clock, reset and count; expected frames come from a decimal reference model.
module tb_seg_scan_display;

  localparam int unsigned SD = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] count = 16'd0;

  logic [2:0] seg_a, seg_c;
  logic [4:0] seg_b;
  logic [6:0] code_a, code_b, code_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  seg_scan_display #(.WIDTH(16), .DIGITS(3), .SCAN_DIV(SD), .BLANK_LZ(1'b1),
                     .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .count(count), .seg(seg_a), .codeout(code_a),
    .busy(busy_a), .ovf(ovf_a));

  seg_scan_display #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(SD), .BLANK_LZ(1'b1),
                     .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .count(count), .seg(seg_b), .codeout(code_b),
    .busy(busy_b), .ovf(ovf_b));

  seg_scan_display #(.WIDTH(16), .DIGITS(3), .SCAN_DIV(SD), .BLANK_LZ(1'b1),
                     .SEG_ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .count(count), .seg(seg_c), .codeout(code_c),
    .busy(busy_c), .ovf(ovf_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig_pat(input int unsigned d);
    logic [6:0] c;
    case (d)
      0: c = 7'h3F;  1: c = 7'h06;  2: c = 7'h5B;  3: c = 7'h4F;  4: c = 7'h66;
      5: c = 7'h6D;  6: c = 7'h7D;  7: c = 7'h07;  8: c = 7'h7F;  9: c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] exp_code(input int unsigned val, input int unsigned nd,
                                          input int unsigned idx, input bit inv);
    int unsigned lim;
    int unsigned v;
    int unsigned dig[8];
    bit          blank;
    logic [6:0]  c;
    lim = 1;
    for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
    if (val >= lim) begin
      c = 7'h40;
    end else begin
      v = val;
      for (int i = 0; i < 8; i++) begin
        dig[i] = v % 10;
        v      = v / 10;
      end
      blank = (idx > 0);
      for (int unsigned i = idx; i < nd; i++) if (dig[i] != 0) blank = 1'b0;
      c = blank ? 7'h00 : dig_pat(dig[idx]);
    end
    return inv ? ~c : c;
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned n, input int unsigned nd);
    logic [7:0] r;
    r = 8'd0;
    if (n >= SD) begin
      r = 8'd1;
      r = r << (((n / SD) - 1) % nd);
    end
    return r;
  endfunction

  function automatic int seg_idx(input logic [7:0] s);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (s == (8'd1 << i)) r = i;
    return r;
  endfunction

  function automatic bit legal_code(input logic [6:0] c);
    case (c)
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
      7'h00, 7'h40: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  typedef struct packed {
    int unsigned      val;
    logic [2:0][6:0]  ea;
    logic [4:0][6:0]  eb;
    logic [2:0][6:0]  ec;
    logic             ova;
    logic             ovb;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input int unsigned v);
    exp_t e;
    e.val = v;
    for (int unsigned i = 0; i < 3; i++) begin
      e.ea[i] = exp_code(v, 3, i, 1'b0);
      e.ec[i] = exp_code(v, 3, i, 1'b1);
    end
    for (int unsigned i = 0; i < 5; i++) e.eb[i] = exp_code(v, 5, i, 1'b0);
    e.ova = (v >= 1000);
    e.ovb = (v >= 100000);
    sb_q.push_back(e);
  endtask

  // Scan-rate monitor: seg timing modelled from cycles since reset release.
  int unsigned cyc;
  bit          mon_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check_eq("seg_a", {29'd0, seg_a}, {24'd0, exp_seg(cyc, 3)});
      check_eq("seg_b", {27'd0, seg_b}, {24'd0, exp_seg(cyc, 5)});
      check_eq("seg_c", {29'd0, seg_c}, {29'd0, ~exp_seg(cyc, 3) & 8'h07});
      check_eq("code_legal", {31'd0, legal_code(code_a)}, 32'd1);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_a !== 1'b0 && n < 40);
    check_eq("idle_timeout", {31'd0, busy_a}, 32'd0);
  endtask

  // Entered at the negedge of the IDLE cycle; follows the conversion and checks one frame.
  task automatic track(input bit do_lat, input int unsigned prev, input int unsigned nv,
                       input bit chg, input logic [15:0] chg_val);
    logic [6:0] ga[3];
    logic [6:0] gb[5];
    logic [6:0] gc[3];
    int         i;
    exp_t       e;
    for (int k = 0; k < 3; k++) begin ga[k] = 'x; gc[k] = 'x; end
    for (int k = 0; k < 5; k++) gb[k] = 'x;
    @(negedge clk);
    check_eq("busy_start", {31'd0, busy_a}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (chg && k == 5) count = chg_val;
    end
    check_eq("busy_last", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check_eq("busy_end", {31'd0, busy_a}, 32'd0);
    i = seg_idx({5'd0, seg_a});
    if (do_lat) check_eq("lat_old", {25'd0, code_a}, {25'd0, exp_code(prev, 3, i, 1'b0)});
    @(negedge clk);
    i = seg_idx({5'd0, seg_a});
    if (do_lat) check_eq("lat_new", {25'd0, code_a}, {25'd0, exp_code(nv, 3, i, 1'b0)});
    e = sb_q.pop_front();
    check_eq($sformatf("v%0d_ovf_a", e.val), {31'd0, ovf_a}, {31'd0, e.ova});
    check_eq($sformatf("v%0d_ovf_b", e.val), {31'd0, ovf_b}, {31'd0, e.ovb});
    check_eq($sformatf("v%0d_ovf_c", e.val), {31'd0, ovf_c}, {31'd0, e.ova});
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      i = seg_idx({5'd0, seg_a});
      if (i >= 0 && i < 3) ga[i] = code_a;
      i = seg_idx({3'd0, seg_b});
      if (i >= 0 && i < 5) gb[i] = code_b;
      i = seg_idx({5'd0, ~seg_c});
      if (i >= 0 && i < 3) gc[i] = code_c;
    end
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("v%0d_a_dig%0d", e.val, k), {25'd0, ga[k]}, {25'd0, e.ea[k]});
      check_eq($sformatf("v%0d_c_dig%0d", e.val, k), {25'd0, gc[k]}, {25'd0, e.ec[k]});
    end
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("v%0d_b_dig%0d", e.val, k), {25'd0, gb[k]}, {25'd0, e.eb[k]});
  endtask

  task automatic run_vec(input int unsigned v, input int unsigned prev);
    wait_idle();
    push_exp(v);
    count = v[15:0];
    track(1'b1, prev, v, 1'b0, 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg_a"}, {29'd0, seg_a}, 32'd0);
    check_eq({tag, "_seg_b"}, {27'd0, seg_b}, 32'd0);
    check_eq({tag, "_code_a"}, {25'd0, code_a}, 32'h00);
    check_eq({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
    check_eq({tag, "_ovf_a"}, {31'd0, ovf_a}, 32'd0);
    check_eq({tag, "_seg_c"}, {29'd0, seg_c}, 32'h7);
    check_eq({tag, "_code_c"}, {25'd0, code_c}, 32'h7F);
  endtask

  // Entered at the negedge where rst_n is released with count = 0.
  task automatic startup_checks();
    @(negedge clk);
    check_eq("st_busy1", {31'd0, busy_a}, 32'd1);
    check_eq("st_code1", {25'd0, code_a}, 32'h00);
    @(negedge clk);
    check_eq("st_code2", {25'd0, code_a}, 32'h00);
    @(negedge clk);
    check_eq("st_code3_a", {25'd0, code_a}, 32'h3F);
    check_eq("st_code3_b", {25'd0, code_b}, 32'h3F);
    check_eq("st_code3_c", {25'd0, code_c}, 32'h40);
    repeat (14) @(negedge clk);
    check_eq("st_busy17", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check_eq("st_busy18", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    startup_checks();

    run_vec(407, 0);
    run_vec(999, 407);
    run_vec(1000, 999);

    // Reset in the middle of a shift while the display is showing overflow.
    wait_idle();
    repeat (5) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    check_eq("pre_rst_ovf", {31'd0, ovf_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    count = 16'd0;
    rst_n = 1'b1;
    startup_checks();

    run_vec(65535, 0);
    run_vec(8, 65535);
    run_vec(10, 8);
    run_vec(100, 10);

    // Count changes mid-shift: in-flight value commits, new one a conversion later.
    wait_idle();
    push_exp(123);
    count = 16'd123;
    track(1'b1, 100, 123, 1'b1, 16'd45);
    wait_idle();
    push_exp(45);
    track(1'b0, 45, 45, 1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
